// File: rtl/muldiv_ctl_pkg.sv
// Shared constants, command encodings and FSM states for the mul/div sequencer.
package muldiv_ctl_pkg;

  localparam int CPU_REG_WIDTH  = 32;
  localparam int CPU_MDOP_WIDTH = 3;

  localparam logic [CPU_MDOP_WIDTH-1:0] CPU_MDOP_MULT  = 3'd0;
  localparam logic [CPU_MDOP_WIDTH-1:0] CPU_MDOP_MULTU = 3'd1;
  localparam logic [CPU_MDOP_WIDTH-1:0] CPU_MDOP_DIV   = 3'd2;
  localparam logic [CPU_MDOP_WIDTH-1:0] CPU_MDOP_DIVU  = 3'd3;
  localparam logic [CPU_MDOP_WIDTH-1:0] CPU_MDOP_MTHI  = 3'd4;
  localparam logic [CPU_MDOP_WIDTH-1:0] CPU_MDOP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Magnitude of a two's-complement value when en is set, otherwise pass-through.
  // 0x8000_0000 maps to itself, which the unsigned datapath reads as 2^31.
  function automatic logic [CPU_REG_WIDTH-1:0] abs_word(input logic [CPU_REG_WIDTH-1:0] v,
                                                       input logic en);
    return (en && v[CPU_REG_WIDTH-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Iteration datapath: operand latch, sign stripping, radix-2 shift-add multiply /
// restoring divide steps, and the final sign fix-up of the result.
module muldiv_dp
  import muldiv_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        load,       // latch raw operands (accept edge)
  input  logic        prep,       // strip signs, clear accumulator
  input  logic        step,       // one multiply/divide iteration
  input  logic        is_div,
  input  logic        is_signed,
  input  logic        dz,         // divide-by-zero result override
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_rt_zero,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo
);

  // a_q keeps raw rs for the divide-by-zero HI value; b_q is multiplicand/divisor;
  // {acc_q, lo_q} is the 64-bit product / remainder:quotient pair.
  logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d, lo_q, lo_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic [32:0] rem_sh, diff, sum;
  logic [63:0] prod, prod_neg;

  assign o_rt_zero = (b_q == 32'd0);

  // Next-state for the operand and accumulator registers.
  always_comb begin
    // NOTE: every signal is given a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sh    = {acc_q, lo_q[31]};
    diff      = rem_sh - {1'b0, b_q};
    sum       = lo_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};

    if (load) begin
      a_d       = i_rs;
      b_d       = i_rt;
      acc_d     = 32'd0;
      lo_d      = 32'd0;
      neg_quo_d = 1'b0;
      neg_rem_d = 1'b0;
    end else if (prep) begin
      lo_d      = abs_word(a_q, is_signed);
      b_d       = abs_word(b_q, is_signed);
      acc_d     = 32'd0;
      neg_quo_d = is_signed & (a_q[31] ^ b_q[31]);
      neg_rem_d = is_signed & a_q[31];
    end else if (step) begin
      if (is_div) begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (!diff[32]) begin
          acc_d = diff[31:0];
          lo_d  = {lo_q[30:0], 1'b1};
        end else begin
          acc_d = rem_sh[31:0];
          lo_d  = {lo_q[30:0], 1'b0};
        end
      end else begin
        // Add multiplicand on a set multiplier bit, then shift the pair right.
        {acc_d, lo_d} = {sum, lo_q[31:1]};
      end
    end
  end

  // Result formatting applied at the FIX edge by the controller.
  always_comb begin
    prod     = {acc_q, lo_q};
    prod_neg = ~prod + 64'd1;
    o_res_hi = 32'd0;
    o_res_lo = 32'd0;
    if (dz) begin
      o_res_hi = a_q;
      o_res_lo = 32'hFFFF_FFFF;
    end else if (is_div) begin
      o_res_lo = neg_quo_q ? (~lo_q + 32'd1) : lo_q;
      o_res_hi = neg_rem_q ? (~acc_q + 32'd1) : acc_q;
    end else begin
      o_res_hi = neg_quo_q ? prod_neg[63:32] : prod[63:32];
      o_res_lo = neg_quo_q ? prod_neg[31:0]  : prod[31:0];
    end
  end

  // Datapath registers, cleared on reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc_q     <= 32'd0;
      lo_q      <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/muldiv_ctl.sv
// Mul/div sequencer: owns HI/LO, accepts commands from execute, drives the
// iteration datapath and produces the execute-stage stall term.
module muldiv_ctl
  import muldiv_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_cmd_valid,
  input  logic [2:0]  i_cmd_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_cmd_ready,
  input  logic        i_hilo_rd,
  output logic        o_stall,
  input  logic        i_abort,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        accept, load, prep, step, is_div, is_signed, rt_zero;
  logic [31:0] res_hi, res_lo;

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_stall     = (i_cmd_valid && !o_cmd_ready) || (i_hilo_rd && o_busy);
  assign o_hi        = hi_q;
  assign o_lo        = lo_q;

  // A flush cancels any command presented in the same cycle.
  assign accept    = i_cmd_valid && o_cmd_ready && !i_abort;
  assign is_div    = (op_q == CPU_MDOP_DIV)  || (op_q == CPU_MDOP_DIVU);
  assign is_signed = (op_q == CPU_MDOP_MULT) || (op_q == CPU_MDOP_DIV);

  muldiv_dp u_dp (
    .clk       (clk),
    .nrst      (nrst),
    .load      (load),
    .prep      (prep),
    .step      (step),
    .is_div    (is_div),
    .is_signed (is_signed),
    .dz        (dz_q),
    .i_rs      (i_rs),
    .i_rt      (i_rt),
    .o_rt_zero (rt_zero),
    .o_res_hi  (res_hi),
    .o_res_lo  (res_lo)
  );

  // Next-state, datapath strobes and HI/LO write selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    prep    = 1'b0;
    step    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (i_cmd_op)
            CPU_MDOP_MULT, CPU_MDOP_MULTU, CPU_MDOP_DIV, CPU_MDOP_DIVU: begin
              op_d    = i_cmd_op;
              dz_d    = 1'b0;
              cnt_d   = 5'd0;
              load    = 1'b1;
              state_d = ST_PREP;
            end
            CPU_MDOP_MTHI: hi_d = i_rs;
            CPU_MDOP_MTLO: lo_d = i_rs;
            default: ;  // reserved encodings are accepted and ignored
          endcase
        end
      end
      ST_PREP: begin
        prep  = 1'b1;
        cnt_d = 5'd0;
        if (is_div && rt_zero) begin
          dz_d    = 1'b1;
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush of an in-flight op: back to IDLE without touching HI/LO.
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      step    = 1'b0;
      prep    = 1'b0;
    end
  end

  // Controller state and the architectural HI/LO pair.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
